// File: rtl/ripple_add_sequencer_if.sv
// ripple_add_sequencer_if: operand/result handshake bundle for ripple_add_sequencer
//   in_valid/in_ready + a, b, sub, cin : operand side (producer -> block)
//   out_valid/out_ready + sum, cout, ovf : result side (block -> consumer)
//   busy : status, high while an operation is in flight or its result is held
interface ripple_add_sequencer_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: WIDTH-bit add/sub built from one 4-bit slice, one slice per clock
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ripple_add_sequencer_if.slave (operand handshake, result handshake, busy)
module ripple_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ripple_add_sequencer_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
            $error("ripple_add_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [KW-1:0]    k;
    logic [KW+1:0]    sh;
    logic [3:0]       a_sl;
    logic [3:0]       b_sl;
    logic [4:0]       sl_sum;
    logic [WIDTH-1:0] next_acc;

    // Slice k sits at bit offset 4k; shifting avoids variable part-selects.
    always_comb begin
        sh       = {k, 2'b00};
        a_sl     = 4'(op_a >> sh);
        b_sl     = 4'(op_b >> sh);
        sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0, carry};
        next_acc = (acc & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sl_sum[3:0]) << sh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_a          <= '0;
            op_b          <= '0;
            acc           <= '0;
            carry         <= 1'b0;
            k             <= '0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    // Subtraction is A + ~B + ~borrow.
                    op_a         <= bus.a;
                    op_b         <= bus.sub ? ~bus.b : bus.b;
                    carry        <= bus.sub ? ~bus.cin : bus.cin;
                    acc          <= '0;
                    k            <= '0;
                    state        <= RUN;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                end
                RUN: begin
                    acc   <= next_acc;
                    carry <= sl_sum[4];
                    k     <= k + 1'b1;
                    if (k == KW'(NSLICE - 1)) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.sum       <= next_acc;
                        bus.cout      <= sl_sum[4];
                        bus.ovf       <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                         (next_acc[WIDTH-1] != op_a[WIDTH-1]);
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
